// File: rtl/mc_controller.sv
// Purpose: multi-cycle MIPS sequencer; walks each instruction FETCH->DECODE->EXEC/MEM/WB/BRANCH/JUMP.
// Latency: 3 cycles (branch/jump), 4 (ALU, sw), 5 (lw) with zero memory wait states.
// Backpressure: FETCH/MEM_RD/MEM_WR hold their request and controls until mem_ready; elsewhere mem_ready is ignored.
//
// Ports:
//   clk, reset            rising-edge clock; async active-high reset (state FETCH, counters cleared)
//   opcode, func, rt      instruction register fields, valid from DECODE onward
//   zero[8:0]             registered compare flags ([4] eq, [3] slt, [6] sltu, [2] gtz, [1] eqz, [0] ltz)
//   mem_ready             shared memory port completes the current access this cycle
//   pc_we .. slts_real    combinational datapath strobes for the current state
//   illegal               sticky flag, set when an unsupported instruction is decoded
//   instret               retired instruction counter (wraps)
module mc_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic [4:0]  rt,
  input  logic [8:0]  zero,
  input  logic        mem_ready,
  output logic        pc_we,
  output logic        ir_we,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_we,
  output logic [1:0]  RegDst,
  output logic        AluSrc,
  output logic [1:0]  PCsrc,
  output logic [1:0]  MemToReg,
  output logic        ExtOp,
  output logic [2:0]  AluOp,
  output logic        slts_real,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP, TRAP
  } state_t;

  state_t state;

  // Instruction decode (standard MIPS-I encodings)
  logic is_rtype;
  logic op_addu, op_subu, op_slt, op_sltu, op_jr;
  logic op_ori, op_lui, op_slti, op_sltiu, op_lw, op_sw;
  logic op_beq, op_bne, op_blez, op_bgtz, op_bltz, op_bgez, op_jal;
  logic is_alu, is_branch, is_jump, is_slt_fam;

  assign is_rtype  = (opcode == 6'h00);
  assign op_addu   = is_rtype && (func == 6'h21);
  assign op_subu   = is_rtype && (func == 6'h23);
  assign op_slt    = is_rtype && (func == 6'h2a);
  assign op_sltu   = is_rtype && (func == 6'h2b);
  assign op_jr     = is_rtype && (func == 6'h08);
  assign op_ori    = (opcode == 6'h0d);
  assign op_lui    = (opcode == 6'h0f);
  assign op_slti   = (opcode == 6'h0a);
  assign op_sltiu  = (opcode == 6'h0b);
  assign op_lw     = (opcode == 6'h23);
  assign op_sw     = (opcode == 6'h2b);
  assign op_beq    = (opcode == 6'h04);
  assign op_bne    = (opcode == 6'h05);
  assign op_blez   = (opcode == 6'h06);
  assign op_bgtz   = (opcode == 6'h07);
  assign op_bltz   = (opcode == 6'h01) && (rt == 5'b00000);
  assign op_bgez   = (opcode == 6'h01) && (rt == 5'b00001);
  assign op_jal    = (opcode == 6'h03);

  assign is_alu     = op_addu | op_subu | op_slt | op_sltu | op_ori | op_lui | op_slti | op_sltiu;
  assign is_branch  = op_beq | op_bne | op_blez | op_bgtz | op_bltz | op_bgez;
  assign is_jump    = op_jal | op_jr;
  assign is_slt_fam = op_slt | op_sltu | op_slti | op_sltiu;

  // Flags not consumed by any supported instruction
  logic unused_flags;
  assign unused_flags = &{1'b0, zero[8:7], zero[5]};

  // ALU controls shared by EXEC and WB so the datapath result stays stable into write-back.
  // The slt family runs a subtract; the actual compare bit comes from the zero flags.
  logic       alu_src_d, ext_op_d;
  logic [2:0] alu_op_d;
  always_comb begin
    alu_src_d = op_lw | op_sw | op_ori | op_lui | op_slti | op_sltiu;
    ext_op_d  = op_lw | op_sw | op_slti | op_sltiu;
    alu_op_d  = 3'b000;
    if (op_subu | is_slt_fam) alu_op_d = 3'b001;
    else if (op_ori)          alu_op_d = 3'b011;
    else if (op_lui)          alu_op_d = 3'b100;
  end

  logic taken;
  assign taken = (op_beq  &  zero[4]) |
                 (op_bne  & ~zero[4]) |
                 (op_bgez & (zero[2] | zero[1])) |
                 (op_bgtz &  zero[2]) |
                 (op_blez & (zero[1] | zero[0])) |
                 (op_bltz &  zero[0]);

  // State, sticky illegal flag and retire counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FETCH;
      illegal <= 1'b0;
      instret <= 32'd0;
    end else begin
      case (state)
        FETCH:  if (mem_ready) state <= DECODE;
        DECODE: begin
          if (is_alu | op_lw | op_sw) state <= EXEC;
          else if (is_branch)         state <= BRANCH;
          else if (is_jump)           state <= JUMP;
          else begin
            state   <= TRAP;
            illegal <= 1'b1;
          end
        end
        EXEC: begin
          if (op_lw)      state <= MEM_RD;
          else if (op_sw) state <= MEM_WR;
          else            state <= WB;
        end
        MEM_RD: if (mem_ready) state <= WB;
        MEM_WR: begin
          if (mem_ready) begin
            state   <= FETCH;
            instret <= instret + 32'd1;
          end
        end
        WB, BRANCH, JUMP: begin
          state   <= FETCH;
          instret <= instret + 32'd1;
        end
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Strobes: gated by reset so an aborted instruction has no side effects
  always_comb begin
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    reg_we    = 1'b0;
    RegDst    = 2'b00;
    AluSrc    = 1'b0;
    PCsrc     = 2'b00;
    MemToReg  = 2'b00;
    ExtOp     = 1'b0;
    AluOp     = 3'b000;
    slts_real = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end
        end
        EXEC: begin
          AluSrc = alu_src_d;
          ExtOp  = ext_op_d;
          AluOp  = alu_op_d;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          AluSrc   = 1'b1;
          ExtOp    = 1'b1;
        end
        MEM_WR: mem_write = 1'b1;
        WB: begin
          reg_we    = 1'b1;
          AluSrc    = alu_src_d;
          ExtOp     = ext_op_d;
          AluOp     = alu_op_d;
          RegDst    = is_rtype ? 2'b01 : 2'b00;
          MemToReg  = op_lw ? 2'b01 : (is_slt_fam ? 2'b11 : 2'b00);
          slts_real = ((op_slt | op_slti) & zero[3]) | ((op_sltu | op_sltiu) & zero[6]);
        end
        BRANCH: begin
          ExtOp = 1'b1;
          if (taken) begin
            pc_we = 1'b1;
            PCsrc = 2'b01;
          end
        end
        JUMP: begin
          if (op_jal) begin
            pc_we    = 1'b1;
            PCsrc    = 2'b10;
            reg_we   = 1'b1;
            RegDst   = 2'b10;
            MemToReg = 2'b10;
          end else if (op_jr) begin
            pc_we = 1'b1;
            PCsrc = 2'b11;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Purpose: directed self-checking bench for mc_controller (vector table plus multi-cycle sequences).
// Latency: checks every instruction class at its expected cycle count.
// Backpressure: exercises mem_ready wait states in FETCH and MEM_RD, and reset during MEM_WR.
module tb_mc_controller;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic [4:0]  rt;
  logic [8:0]  zero;
  logic        mem_ready;
  logic        pc_we, ir_we, mem_read, mem_write, reg_we;
  logic [1:0]  RegDst;
  logic        AluSrc;
  logic [1:0]  PCsrc;
  logic [1:0]  MemToReg;
  logic        ExtOp;
  logic [2:0]  AluOp;
  logic        slts_real;
  logic        illegal;
  logic [31:0] instret;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .rt(rt), .zero(zero),
    .mem_ready(mem_ready), .pc_we(pc_we), .ir_we(ir_we), .mem_read(mem_read),
    .mem_write(mem_write), .reg_we(reg_we), .RegDst(RegDst), .AluSrc(AluSrc),
    .PCsrc(PCsrc), .MemToReg(MemToReg), .ExtOp(ExtOp), .AluOp(AluOp),
    .slts_real(slts_real), .illegal(illegal), .instret(instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed strobe bundle: pc_we ir_we mem_read mem_write reg_we RegDst AluSrc PCsrc MemToReg ExtOp AluOp slts_real
  logic [16:0] obs;
  assign obs = {pc_we, ir_we, mem_read, mem_write, reg_we, RegDst, AluSrc, PCsrc, MemToReg, ExtOp, AluOp, slts_real};

  function automatic logic [16:0] mk(input logic pw, input logic iw, input logic mr, input logic mw,
                                     input logic rw, input logic [1:0] rd, input logic as,
                                     input logic [1:0] pcs, input logic [1:0] mtr, input logic ext,
                                     input logic [2:0] aop, input logic sr);
    return {pw, iw, mr, mw, rw, rd, as, pcs, mtr, ext, aop, sr};
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rtf;
    logic [8:0]  zf;
    int          ncyc;
    logic [16:0] last;
  } vec_t;

  localparam int NV = 19;
  vec_t        vecs [NV];
  logic [16:0] fetch_ok, fetch_wait, idle, lw_exec, lw_mem, lw_wb, sw_exec, sw_mem;
  logic        rdy_a [8];
  logic [16:0] exp_a [8];
  int          exp_instret;

  initial begin
    fetch_ok   = mk(1,1,1,0,0,2'b00,0,2'b00,2'b00,0,3'b000,0);
    fetch_wait = mk(0,0,1,0,0,2'b00,0,2'b00,2'b00,0,3'b000,0);
    idle       = 17'd0;
    lw_exec    = mk(0,0,0,0,0,2'b00,1,2'b00,2'b00,1,3'b000,0);
    lw_mem     = mk(0,0,1,0,0,2'b00,1,2'b00,2'b00,1,3'b000,0);
    lw_wb      = mk(0,0,0,0,1,2'b00,1,2'b00,2'b01,1,3'b000,0);
    sw_exec    = lw_exec;
    sw_mem     = mk(0,0,0,1,0,2'b00,0,2'b00,2'b00,0,3'b000,0);

    //            op     func   rt     zero     cyc  expected strobes on the last cycle
    vecs[0]  = '{6'h00, 6'h21, 5'd0, 9'h000, 4, mk(0,0,0,0,1,2'b01,0,2'b00,2'b00,0,3'b000,0)}; // addu
    vecs[1]  = '{6'h00, 6'h23, 5'd0, 9'h000, 4, mk(0,0,0,0,1,2'b01,0,2'b00,2'b00,0,3'b001,0)}; // subu
    vecs[2]  = '{6'h00, 6'h2a, 5'd0, 9'h008, 4, mk(0,0,0,0,1,2'b01,0,2'b00,2'b11,0,3'b001,1)}; // slt true
    vecs[3]  = '{6'h00, 6'h2a, 5'd0, 9'h040, 4, mk(0,0,0,0,1,2'b01,0,2'b00,2'b11,0,3'b001,0)}; // slt false
    vecs[4]  = '{6'h00, 6'h2b, 5'd0, 9'h040, 4, mk(0,0,0,0,1,2'b01,0,2'b00,2'b11,0,3'b001,1)}; // sltu true
    vecs[5]  = '{6'h0d, 6'h00, 5'd0, 9'h000, 4, mk(0,0,0,0,1,2'b00,1,2'b00,2'b00,0,3'b011,0)}; // ori
    vecs[6]  = '{6'h0f, 6'h00, 5'd0, 9'h000, 4, mk(0,0,0,0,1,2'b00,1,2'b00,2'b00,0,3'b100,0)}; // lui
    vecs[7]  = '{6'h0b, 6'h00, 5'd0, 9'h040, 4, mk(0,0,0,0,1,2'b00,1,2'b00,2'b11,1,3'b001,1)}; // sltiu true
    vecs[8]  = '{6'h0a, 6'h00, 5'd0, 9'h040, 4, mk(0,0,0,0,1,2'b00,1,2'b00,2'b11,1,3'b001,0)}; // slti false
    vecs[9]  = '{6'h23, 6'h00, 5'd0, 9'h000, 5, lw_wb};                                        // lw
    vecs[10] = '{6'h2b, 6'h00, 5'd0, 9'h000, 4, sw_mem};                                       // sw
    vecs[11] = '{6'h04, 6'h00, 5'd0, 9'h010, 3, mk(1,0,0,0,0,2'b00,0,2'b01,2'b00,1,3'b000,0)}; // beq taken
    vecs[12] = '{6'h05, 6'h00, 5'd0, 9'h010, 3, mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,3'b000,0)}; // bne not taken
    vecs[13] = '{6'h01, 6'h00, 5'd1, 9'h002, 3, mk(1,0,0,0,0,2'b00,0,2'b01,2'b00,1,3'b000,0)}; // bgez taken (A==0)
    vecs[14] = '{6'h07, 6'h00, 5'd0, 9'h002, 3, mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,3'b000,0)}; // bgtz not taken
    vecs[15] = '{6'h06, 6'h00, 5'd0, 9'h001, 3, mk(1,0,0,0,0,2'b00,0,2'b01,2'b00,1,3'b000,0)}; // blez taken
    vecs[16] = '{6'h01, 6'h00, 5'd0, 9'h004, 3, mk(0,0,0,0,0,2'b00,0,2'b00,2'b00,1,3'b000,0)}; // bltz not taken
    vecs[17] = '{6'h03, 6'h00, 5'd0, 9'h000, 3, mk(1,0,0,0,1,2'b10,0,2'b10,2'b10,0,3'b000,0)}; // jal
    vecs[18] = '{6'h00, 6'h08, 5'd0, 9'h000, 3, mk(1,0,0,0,0,2'b00,0,2'b11,2'b00,0,3'b000,0)}; // jr

    // lw with one FETCH wait and two MEM_RD waits; mem_ready low in DECODE/EXEC/WB must be ignored
    rdy_a = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    exp_a = '{fetch_wait, fetch_ok, idle, lw_exec, lw_mem, lw_mem, lw_mem, lw_wb};

    exp_instret = 0;
    reset = 1'b1; opcode = 6'h00; func = 6'h00; rt = 5'd0; zero = 9'h000; mem_ready = 1'b0;

    // Reset state: all strobes low even though the state is FETCH
    @(negedge clk); #1;
    check("reset_strobes", {15'd0, obs}, {15'd0, idle});
    check("reset_illegal", {31'd0, illegal}, 32'd0);
    check("reset_instret", instret, 32'd0);
    reset = 1'b0;

    // Zero-wait-state vector table
    for (int i = 0; i < NV; i++) begin
      for (int c = 1; c <= vecs[i].ncyc; c++) begin
        @(negedge clk);
        opcode = vecs[i].op; func = vecs[i].fn; rt = vecs[i].rtf; zero = vecs[i].zf; mem_ready = 1'b1;
        #1;
        if (c == 1) begin
          check($sformatf("vec%0d_fetch", i), {15'd0, obs}, {15'd0, fetch_ok});
          check($sformatf("vec%0d_instret", i), instret, exp_instret);
        end else if (c == vecs[i].ncyc) begin
          check($sformatf("vec%0d_last", i), {14'd0, illegal, obs}, {14'd0, 1'b0, vecs[i].last});
        end else if (c == 2) begin
          check($sformatf("vec%0d_decode", i), {15'd0, obs}, {15'd0, idle});
        end
      end
      exp_instret++;
    end

    // lw with wait states
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      opcode = 6'h23; func = 6'h00; rt = 5'd0; zero = 9'h000; mem_ready = rdy_a[c];
      #1;
      check($sformatf("lw_wait_c%0d", c), {15'd0, obs}, {15'd0, exp_a[c]});
      if (c == 0) check("lw_wait_instret_before", instret, exp_instret);
    end
    exp_instret++;

    // Unsupported opcode: trap holds with no strobes and no retirement
    @(negedge clk);
    opcode = 6'h3f; mem_ready = 1'b1; #1;
    check("trap_fetch_instret", instret, exp_instret);
    @(negedge clk); #1;
    check("trap_decode", {14'd0, illegal, obs}, {14'd0, 1'b0, idle});
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mem_ready = c[0]; #1;
      check($sformatf("trap_c%0d", c), {14'd0, illegal, obs}, {14'd0, 1'b1, idle});
    end
    check("trap_instret", instret, exp_instret);

    // Reset clears the trap; then abort a sw while it waits in MEM_WR
    @(negedge clk);
    reset = 1'b1; mem_ready = 1'b0; #1;
    exp_instret = 0;
    check("rst_trap_illegal", {31'd0, illegal}, 32'd0);
    check("rst_trap_instret", instret, 32'd0);
    @(negedge clk); #1;
    check("rst_hold_strobes", {15'd0, obs}, {15'd0, idle});
    reset = 1'b0;

    @(negedge clk);
    opcode = 6'h2b; mem_ready = 1'b1; #1;
    check("sw_abort_fetch", {15'd0, obs}, {15'd0, fetch_ok});
    @(negedge clk); mem_ready = 1'b0; #1;
    check("sw_abort_decode", {15'd0, obs}, {15'd0, idle});
    @(negedge clk); #1;
    check("sw_abort_exec", {15'd0, obs}, {15'd0, sw_exec});
    @(negedge clk); #1;
    check("sw_abort_memwr", {15'd0, obs}, {15'd0, sw_mem});
    #1 reset = 1'b1;
    #1;
    check("sw_abort_drop", {14'd0, illegal, obs}, {14'd0, 1'b0, idle});
    @(negedge clk); #1;
    check("sw_abort_instret", instret, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    check("after_abort_fetch_wait", {15'd0, obs}, {15'd0, fetch_wait});
    check("after_abort_instret", instret, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multi-cycle sequencing controller for the MIPS datapath. It replaces single-cycle decode with a state machine that walks each instruction through fetch, decode, execute, memory and write-back. It asserts per-state datapath strobes and stalls on a memory ready handshake. It sits between the instruction register, the ALU/compare flags and the shared instruction/data memory port.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state FETCH and clears counters
- opcode  in  6  IR[31:26]; valid from DECODE onward
- func  in  6  IR[5:0]
- rt  in  5  IR[20:16]; selects bltz (00000) / bgez (00001) under opcode 000001
- zero  in  9  compare flags, registered in datapath: [4] A==B, [3] A<B signed, [6] A<B unsigned, [2] A>0, [1] A==0, [0] A<0
- mem_ready  in  1  memory port completes the current read/write this cycle
- pc_we  out  1  PC write enable
- ir_we  out  1  instruction register load
- mem_read  out  1  memory read request, held until mem_ready
- mem_write  out  1  memory write request, held until mem_ready
- reg_we  out  1  register file write enable
- RegDst  out  2  00 rt, 01 rd, 10 $31
- AluSrc  out  1  0 register B, 1 extended immediate
- PCsrc  out  2  00 PC+4, 01 branch target, 10 jump target, 11 register (jr)
- MemToReg  out  2  00 ALU, 01 memory, 10 PC+4, 11 compare result
- ExtOp  out  1  1 sign-extend, 0 zero-extend
- AluOp  out  3  000 add, 001 sub, 011 or, 100 lui
- slts_real  out  1  compare result bit written by slt/slti/sltu/sltiu
- illegal  out  1  sticky: unsupported instruction decoded
- instret  out  32  count of retired instructions

## Operation
- Supported: addu, subu, slt, sltu, ori, lui, slti, sltiu, lw, sw, beq, bne, bgez, bgtz, blez, bltz, jal, jr. Encodings are standard MIPS-I.
- States: FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP, TRAP.
- FETCH: mem_read=1. On mem_ready: ir_we=1, pc_we=1, PCsrc=00, go DECODE. Otherwise stay.
- DECODE: no strobes. Next state:
  - ALU/slt class or lw/sw -> EXEC
  - beq/bne/bgez/bgtz/blez/bltz -> BRANCH
  - jal/jr -> JUMP
  - anything else -> TRAP
- EXEC: AluSrc/ExtOp/AluOp driven per instruction, matching WB values. Next state:
  - lw -> MEM_RD
  - sw -> MEM_WR
  - else -> WB
- MEM_RD: mem_read=1, AluSrc=1, ExtOp=1. On mem_ready go WB.
- MEM_WR: mem_write=1. On mem_ready go FETCH; the instruction retires.
- WB: reg_we=1 for one cycle, then go FETCH.
  - R-type: RegDst=01.
  - I-type: RegDst=00.
  - lw: MemToReg=01.
  - slt family: MemToReg=11.
  - Otherwise: MemToReg=00.
- BRANCH: ExtOp=1. Taken condition:
  - beq: zero[4]
  - bne: ~zero[4]
  - bgez: zero[2]|zero[1]
  - bgtz: zero[2]
  - blez: zero[1]|zero[0]
  - bltz: zero[0]
  - If taken: pc_we=1, PCsrc=01. Always go FETCH.
- JUMP:
  - jal: pc_we=1, PCsrc=10, reg_we=1, RegDst=10, MemToReg=10.
  - jr: pc_we=1, PCsrc=11.
  - Go FETCH.
- slts_real: (slt|slti)&zero[3] or (sltu|sltiu)&zero[6]. Otherwise 0.
- ExtOp=1 for lw, sw, branches, slti, sltiu. Zero-extend for ori/lui.
- TRAP: all strobes 0, illegal=1, state held until reset.
- instret increments by 1 on the last cycle of each instruction: WB, MEM_WR completion, BRANCH, JUMP. It wraps 0xFFFFFFFF -> 0.
- Strobes are combinational from state, decoded fields, zero and mem_ready. Every strobe not listed for a state is 0.

## Timing
- Reset (async assert, sync release at next edge):
  - State = FETCH, illegal=0, instret=0.
  - All strobes 0 while reset is high, including mem_read.
- Cycle counts with zero wait states (mem_ready high in the same cycle as the request):
  - ALU/slt/lui/ori: 4
  - lw: 5
  - sw: 4
  - branch (taken or not): 3
  - jal/jr: 3
- Each cycle mem_ready is low in FETCH/MEM_RD/MEM_WR adds one cycle. The request and all address/control outputs stay stable while waiting.
- mem_ready is ignored outside FETCH/MEM_RD/MEM_WR.
- Reset asserted mid-instruction aborts it immediately: no reg_we, pc_we or mem_write after assertion, and the instruction is not counted.
- zero is sampled only in BRANCH and WB; the datapath guarantees it is valid there.

## Test plan
- Reset then addu $3,$1,$2 with mem_ready tied 1 -> states F,D,E,WB. WB cycle: reg_we=1, RegDst=01, MemToReg=00, AluOp=000. instret=1 after 4 cycles.
- lw with mem_ready low 2 cycles in MEM_RD -> mem_read held 3 cycles, reg_we=1 with MemToReg=01 on cycle 7 after DECODE-entry baseline. Total 7 cycles, instret=1.
- beq with zero[4]=1, then bne with zero[4]=1 -> first: pc_we=1, PCsrc=01 in BRANCH. Second: pc_we=0. Each takes 3 cycles.
- jal then jr -> jal JUMP cycle: pc_we=1, PCsrc=10, reg_we=1, RegDst=10, MemToReg=10. jr JUMP cycle: PCsrc=11, reg_we=0.
- sltiu with zero[6]=1, zero[3]=0 -> WB: slts_real=1, MemToReg=11, AluSrc=1, ExtOp=1. slti with the same flags -> slts_real=0.
- Opcode 0x3F -> TRAP: illegal=1, no strobes for 20 cycles, instret unchanged. Reset asserted mid-MEM_WR -> mem_write drops the same cycle, illegal=0, state FETCH.
